// File: rtl/accumulation_buf_mc.sv
// Multi-channel bf16 accumulation buffer: NUM_CH partial sums, each channel total emitted with its channel tag.
// Latency: out_vld rises 1 cycle after the final beat. in_rdy drops only while a held result waits on out_rdy, or during flush.

// Single-cycle FP adder: round-to-nearest-even, subnormals treated as zero, inf/NaN operands passed through.
module fp_add_single_cycle #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 7,
  parameter int SIGN_WIDTH     = 1,
  parameter int FP_WIDTH       = 16
) (
  input  logic [FP_WIDTH-1:0] a_i,
  input  logic [FP_WIDTH-1:0] b_i,
  output logic [FP_WIDTH-1:0] sum_o
);
  localparam int EW = EXP_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam int SB = EXP_WIDTH + MANTISSA_WIDTH + SIGN_WIDTH - 1;
  // hidden bit + mantissa + guard/round/sticky
  localparam int XW = MW + 4;
  localparam logic [EW+1:0] EXP_INF = (EW+2)'((1 << EW) - 1);

  logic [EW-1:0]   ea, eb, el, es, d;
  logic            sl, ss, swap, round_up;
  logic [XW-1:0]   l_ext, s_full, s_al, diff, norm;
  logic [XW:0]     add_sum;
  logic [EW+1:0]   exp_n;
  logic [MW:0]     mant_r;
  int              lz;
  logic            unused_bits;

  function automatic int lzc(input logic [XW-1:0] v);
    int n;
    n = XW;
    for (int i = 0; i < XW; i++) begin
      if (v[i]) n = XW - 1 - i;
    end
    return n;
  endfunction

  assign ea = a_i[SB-1 -: EW];
  assign eb = b_i[SB-1 -: EW];

  always_comb begin
    swap   = b_i[SB-1:0] > a_i[SB-1:0];
    sl     = swap ? b_i[SB] : a_i[SB];
    ss     = swap ? a_i[SB] : b_i[SB];
    el     = swap ? eb : ea;
    es     = swap ? ea : eb;
    l_ext  = {1'b1, (swap ? b_i[MW-1:0] : a_i[MW-1:0]), 3'b000};
    s_full = {1'b1, (swap ? a_i[MW-1:0] : b_i[MW-1:0]), 3'b000};
    d      = el - es;
    if (int'(d) >= XW) s_al = XW'(1);
    else s_al = (s_full >> d) | XW'(|(s_full & ~({XW{1'b1}} << d)));
    add_sum = {1'b0, l_ext} + {1'b0, s_al};
    diff    = l_ext - s_al;
    lz      = lzc(diff);
    exp_n   = {2'b00, el};
    if (ss == sl) begin
      if (add_sum[XW]) begin
        norm  = {add_sum[XW:2], |add_sum[1:0]};
        exp_n = exp_n + (EW+2)'(1);
      end else begin
        norm = add_sum[XW-1:0];
      end
    end else begin
      norm  = diff << lz;
      exp_n = exp_n - (EW+2)'(lz);
    end
    round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r   = {1'b0, norm[XW-2:3]} + (MW+1)'(round_up);
    if (mant_r[MW]) exp_n = exp_n + (EW+2)'(1);

    if (&ea)                          sum_o = a_i;
    else if (&eb)                     sum_o = b_i;
    else if (eb == '0)                sum_o = a_i;
    else if (ea == '0)                sum_o = b_i;
    else if (ss != sl && diff == '0)  sum_o = '0;
    else if (ss != sl && lz >= int'(el)) sum_o = FP_WIDTH'({sl, {SB{1'b0}}});
    else if (exp_n >= EXP_INF)        sum_o = FP_WIDTH'({sl, {EW{1'b1}}, {MW{1'b0}}});
    else                              sum_o = FP_WIDTH'({sl, exp_n[EW-1:0], mant_r[MW-1:0]});
  end

  assign unused_bits = norm[XW-1];
endmodule

module accumulation_buf_mc #(
  parameter int NUM_CH         = 4,
  parameter int MAX_ACCUM      = 32,
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 7,
  parameter int SIGN_WIDTH     = 1,
  parameter int FP_WIDTH       = 16,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int LEN_W          = $clog2(MAX_ACCUM + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LEN_W-1:0]    cfg_accum_len,
  input  logic                flush,
  input  logic [FP_WIDTH-1:0] in_data,
  input  logic [CH_W-1:0]     in_ch,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic [FP_WIDTH-1:0] out_data,
  output logic [CH_W-1:0]     out_ch,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                busy,
  output logic                err_ch_oob
);
  logic [LEN_W-1:0]    cnt_q  [NUM_CH];
  logic [LEN_W-1:0]    cnt_d  [NUM_CH];
  logic [FP_WIDTH-1:0] psum_q [NUM_CH];
  logic [FP_WIDTH-1:0] psum_d [NUM_CH];
  logic [LEN_W-1:0]    len_q, len_d, len_eff, sel_cnt;
  logic [FP_WIDTH-1:0] out_data_q, out_data_d, sel_psum, addend, sum;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic                out_vld_q, out_vld_d, err_q, err_d;
  logic                acc, ch_ok, any_cnt, is_final;

  always_comb begin
    len_eff = cfg_accum_len;
    if (cfg_accum_len == '0) len_eff = LEN_W'(1);
    else if (int'(cfg_accum_len) > MAX_ACCUM) len_eff = LEN_W'(MAX_ACCUM);
  end

  assign in_rdy = ~flush & (~out_vld_q | out_rdy);
  assign acc    = in_vld & in_rdy;
  assign ch_ok  = int'(in_ch) < NUM_CH;

  // Channel select by compare loop so an out-of-range in_ch never indexes the arrays.
  always_comb begin
    sel_cnt  = '0;
    sel_psum = '0;
    any_cnt  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_ch == CH_W'(c)) begin
        sel_cnt  = cnt_q[c];
        sel_psum = psum_q[c];
      end
      if (cnt_q[c] != '0) any_cnt = 1'b1;
    end
  end

  assign addend   = (sel_cnt == '0) ? '0 : sel_psum;
  assign is_final = (sel_cnt == len_q - LEN_W'(1));

  fp_add_single_cycle #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH),
    .SIGN_WIDTH     (SIGN_WIDTH),
    .FP_WIDTH       (FP_WIDTH)
  ) u_fp_add (
    .a_i   (in_data),
    .b_i   (addend),
    .sum_o (sum)
  );

  always_comb begin
    cnt_d      = cnt_q;
    psum_d     = psum_q;
    len_d      = any_cnt ? len_q : len_eff;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    err_d      = acc & ~ch_ok;
    if (flush) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_d[c]  = '0;
        psum_d[c] = '0;
      end
      len_d      = len_eff;
      out_vld_d  = 1'b0;
      out_data_d = '0;
      out_ch_d   = '0;
    end else begin
      if (out_vld_q && out_rdy) begin
        out_vld_d  = 1'b0;
        out_data_d = '0;
        out_ch_d   = '0;
      end
      // A final beat reloads the output stage even while it is being popped.
      if (acc && ch_ok) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (in_ch == CH_W'(c)) begin
            if (is_final) begin
              cnt_d[c]  = '0;
              psum_d[c] = '0;
            end else begin
              cnt_d[c]  = cnt_q[c] + LEN_W'(1);
              psum_d[c] = sum;
            end
          end
        end
        if (is_final) begin
          out_vld_d  = 1'b1;
          out_data_d = sum;
          out_ch_d   = in_ch;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        psum_q[c] <= '0;
      end
      len_q      <= LEN_W'(1);
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      psum_q     <= psum_d;
      len_q      <= len_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      err_q      <= err_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign busy       = any_cnt | out_vld_q;
  assign err_ch_oob = err_q;
endmodule

// File: tb/tb_accumulation_buf_mc.sv
// Directed bench: a 4-channel instance for the datapath, a 3-channel instance for out-of-range channel tags.
module tb_accumulation_buf_mc;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  cfg_accum_len;
  logic        flush, in_vld, out_rdy;
  logic [15:0] in_data;
  logic [1:0]  in_ch;
  logic        in_rdy, out_vld, busy, err_ch_oob;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        in_rdy3, out_vld3, busy3, err3;
  logic [15:0] out_data3;
  logic [1:0]  out_ch3;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  accumulation_buf_mc #(.NUM_CH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_accum_len(cfg_accum_len), .flush(flush),
    .in_data(in_data), .in_ch(in_ch), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_ch(out_ch), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .err_ch_oob(err_ch_oob)
  );

  accumulation_buf_mc #(.NUM_CH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_accum_len(cfg_accum_len), .flush(flush),
    .in_data(in_data), .in_ch(in_ch), .in_vld(in_vld), .in_rdy(in_rdy3),
    .out_data(out_data3), .out_ch(out_ch3), .out_vld(out_vld3), .out_rdy(out_rdy),
    .busy(busy3), .err_ch_oob(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] ch, input logic [15:0] d);
    in_vld = 1'b1; in_ch = ch; in_data = d;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_ch = '0; in_data = '0;
    out_rdy = 1'b1; cfg_accum_len = 6'd4;
    #12;
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL reset_vld got %b want 0", out_vld); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL reset_data got %h want 0000", out_data); end
    tests++; if (out_ch !== 2'd0) begin fails++; $display("FAIL reset_ch got %0d want 0", out_ch); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (err_ch_oob !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_ch_oob); end
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL reset_in_rdy got %b want 1", in_rdy); end
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_len4();
    beat(2'd0, 16'h3F80); beat(2'd0, 16'h4000); beat(2'd0, 16'h4040);
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL len4_early_vld got %b want 0", out_vld); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL len4_busy got %b want 1", busy); end
    beat(2'd0, 16'h4080);
    tests++; if (out_vld !== 1'b1) begin fails++; $display("FAIL len4_vld got %b want 1", out_vld); end
    tests++; if (out_data !== 16'h4120) begin fails++; $display("FAIL len4_data got %h want 4120", out_data); end
    tests++; if (out_ch !== 2'd0) begin fails++; $display("FAIL len4_ch got %0d want 0", out_ch); end
    tick();
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL len4_pop_vld got %b want 0", out_vld); end
    tests++; if (out_data !== 16'h0) begin fails++; $display("FAIL len4_idle_data got %h want 0000", out_data); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL len4_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_interleave();
    cfg_accum_len = 6'd2; tick();
    beat(2'd0, 16'h3F80); beat(2'd1, 16'h4000); beat(2'd0, 16'h4040);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4080 || out_ch !== 2'd0) begin
      fails++; $display("FAIL ilv_ch0 got vld=%b data=%h ch=%0d want 1/4080/0", out_vld, out_data, out_ch); end
    beat(2'd1, 16'h4080);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h40C0 || out_ch !== 2'd1) begin
      fails++; $display("FAIL ilv_ch1 got vld=%b data=%h ch=%0d want 1/40c0/1", out_vld, out_data, out_ch); end
    tick();
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL ilv_drain got %b want 0", out_vld); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    beat(2'd2, 16'h3F80); beat(2'd2, 16'h3F80);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4000 || out_ch !== 2'd2) begin
      fails++; $display("FAIL bp_first got vld=%b data=%h ch=%0d want 1/4000/2", out_vld, out_data, out_ch); end
    in_vld = 1'b1; in_ch = 2'd2; in_data = 16'h4040;
    for (int i = 0; i < 5; i++) begin
      tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL bp_in_rdy[%0d] got %b want 0", i, in_rdy); end
      tests++; if (out_vld !== 1'b1 || out_data !== 16'h4000 || out_ch !== 2'd2) begin
        fails++; $display("FAIL bp_hold[%0d] got vld=%b data=%h ch=%0d want 1/4000/2", i, out_vld, out_data, out_ch); end
      tick();
    end
    out_rdy = 1'b1; #1;
    tests++; if (in_rdy !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b want 1", in_rdy); end
    tick();
    in_vld = 1'b0;
    tests++; if (out_vld !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL bp_after_pop got vld=%b busy=%b want 0/1", out_vld, busy); end
    beat(2'd2, 16'h4040);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h40C0 || out_ch !== 2'd2) begin
      fails++; $display("FAIL bp_no_loss got vld=%b data=%h ch=%0d want 1/40c0/2", out_vld, out_data, out_ch); end
    tick();
  endtask

  task automatic test_len1_continuous();
    logic [15:0] v [4];
    v = '{16'h3F80, 16'h4000, 16'hC0A0, 16'h3E00};
    cfg_accum_len = 6'd0; tick();
    for (int i = 0; i < 4; i++) begin
      beat(2'(i), v[i]);
      tests++; if (out_vld !== 1'b1 || out_data !== v[i] || out_ch !== 2'(i)) begin
        fails++; $display("FAIL len1_beat[%0d] got vld=%b data=%h ch=%0d want 1/%h/%0d", i, out_vld, out_data, out_ch, v[i], i); end
    end
    tick();
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL len1_drain got %b want 0", out_vld); end
  endtask

  task automatic test_flush();
    cfg_accum_len = 6'd4; tick();
    beat(2'd3, 16'h3F80); beat(2'd3, 16'h3F80);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy got %b want 1", busy); end
    flush = 1'b1; in_vld = 1'b1; in_ch = 2'd3; in_data = 16'h3F80; #1;
    tests++; if (in_rdy !== 1'b0) begin fails++; $display("FAIL flush_in_rdy got %b want 0", in_rdy); end
    tick();
    flush = 1'b0; in_vld = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", busy); end
    beat(2'd3, 16'h3F80); beat(2'd3, 16'h3F80); beat(2'd3, 16'h3F80);
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL flush_stale_cnt got vld=%b want 0", out_vld); end
    beat(2'd3, 16'h3F80);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4080 || out_ch !== 2'd3) begin
      fails++; $display("FAIL flush_sum got vld=%b data=%h ch=%0d want 1/4080/3", out_vld, out_data, out_ch); end
    out_rdy = 1'b0; tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    tests++; if (out_vld !== 1'b0 || out_data !== 16'h0) begin
      fails++; $display("FAIL flush_discard got vld=%b data=%h want 0/0000", out_vld, out_data); end
    out_rdy = 1'b1;
  endtask

  task automatic test_cfg_change();
    tick();
    beat(2'd0, 16'h3F80); beat(2'd0, 16'h3F80);
    cfg_accum_len = 6'd2;
    beat(2'd0, 16'h3F80);
    tests++; if (out_vld !== 1'b0) begin fails++; $display("FAIL cfg_midblock got vld=%b want 0", out_vld); end
    beat(2'd0, 16'h3F80);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4080 || out_ch !== 2'd0) begin
      fails++; $display("FAIL cfg_old_len got vld=%b data=%h ch=%0d want 1/4080/0", out_vld, out_data, out_ch); end
    tick();
    beat(2'd1, 16'h3F80); beat(2'd1, 16'h4000);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4040 || out_ch !== 2'd1) begin
      fails++; $display("FAIL cfg_new_len got vld=%b data=%h ch=%0d want 1/4040/1", out_vld, out_data, out_ch); end
    tick();
  endtask

  task automatic test_len_saturate();
    cfg_accum_len = 6'd50; tick();
    for (int i = 0; i < 31; i++) beat(2'd2, 16'h3F80);
    tests++; if (out_vld !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL sat_31 got vld=%b busy=%b want 0/1", out_vld, busy); end
    beat(2'd2, 16'h3F80);
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4200) begin
      fails++; $display("FAIL sat_32 got vld=%b data=%h want 1/4200", out_vld, out_data); end
    tick();
  endtask

  task automatic test_oob();
    flush = 1'b1; tick(); flush = 1'b0;
    cfg_accum_len = 6'd2; tick();
    beat(2'd3, 16'h3F80);
    tests++; if (err3 !== 1'b1) begin fails++; $display("FAIL oob_err got %b want 1", err3); end
    tests++; if (out_vld3 !== 1'b0 || busy3 !== 1'b0) begin
      fails++; $display("FAIL oob_state got vld=%b busy=%b want 0/0", out_vld3, busy3); end
    tests++; if (err_ch_oob !== 1'b0) begin fails++; $display("FAIL oob_valid_ch_err got %b want 0", err_ch_oob); end
    tick();
    tests++; if (err3 !== 1'b0) begin fails++; $display("FAIL oob_pulse got %b want 0", err3); end
    beat(2'd3, 16'h3F80);
    tests++; if (out_vld3 !== 1'b0 || err3 !== 1'b1) begin
      fails++; $display("FAIL oob_second got vld=%b err=%b want 0/1", out_vld3, err3); end
    tests++; if (out_vld !== 1'b1 || out_data !== 16'h4000 || out_ch !== 2'd3) begin
      fails++; $display("FAIL oob_ch3_on4 got vld=%b data=%h ch=%0d want 1/4000/3", out_vld, out_data, out_ch); end
    tick();
  endtask

  initial begin
    test_reset();
    test_len4();
    test_interleave();
    test_backpressure();
    test_len1_continuous();
    test_flush();
    test_cfg_change();
    test_len_saturate();
    test_oob();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
